// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for the ALU operand loader: the ALU opcode values,
// the FSM state encoding and the state width.
package alu_operand_loader_pkg;

  localparam int NB_STATE = 3;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [NB_STATE-1:0] {
    S_OP1  = 3'd0,
    S_OP2  = 3'd1,
    S_OPC  = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_e;

endpackage

// File: rtl/alu_operand_loader_btn_debounce.sv
// Button front end: 2-flop synchronizer, level debouncer and a one-cycle
// pulse on every accepted release->press transition.
module btn_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int NB_DB     = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam logic [NB_DB-1:0] CNT_LAST = NB_DB'(DB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [NB_DB-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sync_d  = {sync_q[0], i_btn};
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        pulse_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update
  // together from the values they held before the edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_pulse = pulse_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Switch/button front end for the ALU: loads op1, op2 and opcode in order,
// then registers the ALU result and carry for display.
module alu_operand_loader
  import alu_operand_loader_pkg::*;
#(
  parameter int NB_DATA   = 8,
  parameter int NB_OPCODE = 6,
  parameter int DB_CYCLES = 4,
  parameter int NB_DB     = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NB_DATA-1:0]   i_sw,
  input  logic                 i_btn_op1,
  input  logic                 i_btn_op2,
  input  logic                 i_btn_opcode,
  input  logic [NB_DATA-1:0]   i_alu_result,
  input  logic                 i_alu_carry,
  output logic [NB_DATA-1:0]   o_op_1,
  output logic [NB_DATA-1:0]   o_op_2,
  output logic [NB_OPCODE-1:0] o_opcode,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_carry,
  output logic                 o_valid,
  output logic [NB_STATE-1:0]  o_state
);

  logic pulse_op1, pulse_op2, pulse_opc;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .NB_DB(NB_DB)) u_db_op1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_op1), .o_pulse(pulse_op1)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES), .NB_DB(NB_DB)) u_db_op2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_op2), .o_pulse(pulse_op2)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES), .NB_DB(NB_DB)) u_db_opc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(i_btn_opcode), .o_pulse(pulse_opc)
  );

  state_e                 state_q, state_d;
  logic [NB_DATA-1:0]     op1_q, op1_d;
  logic [NB_DATA-1:0]     op2_q, op2_d;
  logic [NB_OPCODE-1:0]   opcode_q, opcode_d;
  logic [NB_DATA-1:0]     result_q, result_d;
  logic                   carry_q, carry_d;
  logic                   valid_q, valid_d;

  // Each state listens only to its own button; other pulses are dropped.
  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    opcode_d = opcode_q;
    result_d = result_q;
    carry_d  = carry_q;
    valid_d  = valid_q;
    case (state_q)
      S_OP1: if (pulse_op1) begin
        op1_d   = i_sw;
        state_d = S_OP2;
      end
      S_OP2: if (pulse_op2) begin
        op2_d   = i_sw;
        state_d = S_OPC;
      end
      S_OPC: if (pulse_opc) begin
        opcode_d = i_sw[NB_OPCODE-1:0];
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        result_d = i_alu_result;
        carry_d  = i_alu_carry;
        valid_d  = 1'b1;
        state_d  = S_SHOW;
      end
      S_SHOW: if (pulse_op1) begin
        op1_d   = i_sw;
        valid_d = 1'b0;
        state_d = S_OP2;
      end
      default: state_d = S_OP1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_OP1;
      op1_q    <= '0;
      op2_q    <= '0;
      opcode_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      valid_q  <= valid_d;
    end
  end

  assign o_op_1   = op1_q;
  assign o_op_2   = op2_q;
  assign o_opcode = opcode_q;
  assign o_result = result_q;
  assign o_carry  = carry_q;
  assign o_valid  = valid_q;
  assign o_state  = state_q;

endmodule
